// File: rtl/seg7_pkg.sv
// Shared codes, conversion state type and segment patterns for the 7-segment value display.
package seg7_pkg;

   localparam logic [3:0] DIGIT_DASH  = 4'hA;
   localparam logic [3:0] DIGIT_BLANK = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;

   // Active-low patterns {g,f,e,d,c,b,a}; 0xA is the dash, unused codes are blank.
   localparam logic [6:0] SEG_LUT [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0111111, 7'b1111111,
      7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
   };

   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      return SEG_LUT[code];
   endfunction

endpackage

// File: rtl/bin14_to_bcd.sv
// Sequential double-dabble: 14-bit binary to four BCD nibbles, one shift per clock.
module bin14_to_bcd
   import seg7_pkg::*;
(
   input  logic        clk,
   input  logic        clr_n,
   input  logic        i_start,
   input  logic [13:0] i_bin,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_bcd
);

   conv_state_t r_state, w_state_nxt;
   logic [13:0] r_bin;
   logic [15:0] r_bcd;
   logic [3:0]  r_cnt;
   logic [15:0] w_adj;

   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < 4; i++) begin
         if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (i_start) w_state_nxt = SHIFT;
         SHIFT:   if (r_cnt == 4'd13) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state <= IDLE;
         r_bin   <= '0;
         r_bcd   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && i_start) begin
            r_bin <= i_bin;
            r_bcd <= '0;
            r_cnt <= '0;
         end else if (r_state == SHIFT) begin
            {r_bcd, r_bin} <= {w_adj[14:0], r_bin, 1'b0};
            r_cnt          <= r_cnt + 4'd1;
         end
      end
   end

   assign o_busy = (r_state != IDLE);
   assign o_done = (r_state == DONE);
   assign o_bcd  = r_bcd;

endmodule

// File: rtl/seg7_value_display.sv
// Binary value to 4-digit multiplexed common-anode display. Optional leading-zero
// blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_value_display
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic [13:0] value,
   input  logic        update,
   output logic        busy,
   output logic        ovf,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic             w_busy, w_done, w_accept, w_wrap;
   logic [15:0]      w_bcd;
   logic             r_ovf_next, r_ovf;
   logic [3:0][3:0]  r_d, w_d_nxt;
   logic [CW-1:0]    r_refresh;
   logic [1:0]       r_idx, w_idx_nxt;
   logic [3:0]       r_an;
   logic [6:0]       r_seg;
   logic [3:0]       w_code;

   assign w_accept = update & ~w_busy;

   bin14_to_bcd u_conv (
      .clk     (clk),
      .clr_n   (clr_n),
      .i_start (w_accept),
      .i_bin   (value),
      .o_busy  (w_busy),
      .o_done  (w_done),
      .o_bcd   (w_bcd)
   );

   always_comb begin
      w_d_nxt = r_d;
      if (w_done) w_d_nxt = r_ovf_next ? {4{DIGIT_DASH}} : w_bcd;
   end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic [3:0] r_blank, w_blank_nxt;

   // Blank from the top digit down until the first nonzero; ones digit always shown.
   always_comb begin
      w_blank_nxt = r_blank;
      if (w_done) begin
         w_blank_nxt[3] = ~r_ovf_next & (w_bcd[15:12] == 4'd0);
         w_blank_nxt[2] = w_blank_nxt[3] & (w_bcd[11:8] == 4'd0);
         w_blank_nxt[1] = w_blank_nxt[2] & (w_bcd[7:4] == 4'd0);
         w_blank_nxt[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) r_blank <= '0;
      else        r_blank <= w_blank_nxt;
   end
`else
   logic [3:0] w_blank_nxt;
   assign w_blank_nxt = '0;
`endif

   assign w_wrap    = (r_refresh == CW'(REFRESH_DIV - 1));
   assign w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;
   assign w_code    = w_blank_nxt[w_idx_nxt] ? DIGIT_BLANK : w_d_nxt[w_idx_nxt];

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_ovf_next <= 1'b0;
         r_ovf      <= 1'b0;
         r_d        <= '0;
         r_refresh  <= '0;
         r_idx      <= '0;
         r_an       <= 4'b1110;
         r_seg      <= 7'b1000000;
      end else begin
         if (w_accept) r_ovf_next <= (value > 14'd9999);
         if (w_done)   r_ovf      <= r_ovf_next;
         r_d       <= w_d_nxt;
         r_refresh <= w_wrap ? '0 : r_refresh + CW'(1);
         r_idx     <= w_idx_nxt;
         // Registered from next-state so digit and anode switch on the same edge.
         r_an      <= ~(4'b0001 << w_idx_nxt);
         r_seg     <= seg_decode(w_code);
      end
   end

   assign busy = w_busy;
   assign ovf  = r_ovf;
   assign an   = r_an;
   assign seg  = r_seg;

endmodule

// File: tb/tb_seg7_value_display.sv
// Self-checking bench: random and directed conversions against a decimal-arithmetic display model.
module tb_seg7_value_display;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic [13:0] value = '0;
   logic        update = 1'b0;
   logic        busy, ovf;
   logic [3:0]  an;
   logic [6:0]  seg;

   int errors = 0;
   int checks = 0;
   int ecount;

   int m_code [4];
   bit m_ovf;

   seg7_value_display #(.REFRESH_DIV(4)) dut (
      .clk    (clk),
      .clr_n  (clr_n),
      .value  (value),
      .update (update),
      .busy   (busy),
      .ovf    (ovf),
      .an     (an),
      .seg    (seg)
   );

   always #5 clk = ~clk;

   // Edges since reset release; digit index advances every 4 edges.
   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) ecount <= 0;
      else        ecount <= ecount + 1;
   end

   function automatic logic [6:0] seg_of(input int code);
      case (code)
         0: return 7'b1000000;  1: return 7'b1111001;
         2: return 7'b0100100;  3: return 7'b0110000;
         4: return 7'b0011001;  5: return 7'b0010010;
         6: return 7'b0000010;  7: return 7'b1111000;
         8: return 7'b0000000;  9: return 7'b0010000;
         10: return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic int exp_idx();
      return (ecount / 4) % 4;
   endfunction

   function automatic logic [3:0] exp_an();
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << exp_idx());
   endfunction

   function automatic logic [6:0] exp_seg();
      return seg_of(m_code[exp_idx()]);
   endfunction

   task automatic model_load(input int v);
      if (v > 9999) begin
         m_ovf = 1'b1;
         for (int i = 0; i < 4; i++) m_code[i] = 10;
      end else begin
         m_ovf = 1'b0;
         m_code[0] = v % 10;
         m_code[1] = (v / 10) % 10;
         m_code[2] = (v / 100) % 10;
         m_code[3] = v / 1000;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         for (int i = 3; i > 0; i--) begin
            if (m_code[i] != 0) break;
            m_code[i] = 15;
         end
`endif
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_code[i] = 0;
      m_ovf = 1'b0;
   endtask

   // Issue one update and follow it through the 15-cycle conversion.
   task automatic test_convert(input int v, input string name);
      @(negedge clk);
      value = v[13:0];
      update = 1'b1;
      @(posedge clk);
      @(negedge clk);
      update = 1'b0;
      for (int k = 0; k < 15; k++) begin
         checks++;
         if (busy !== 1'b1 || an !== exp_an() || seg !== exp_seg() || ovf !== m_ovf) begin
            errors++;
            $display("FAIL %s during k=%0d: busy=%b an=%b seg=%b ovf=%b, expected busy=1 an=%b seg=%b ovf=%b",
                     name, k, busy, an, seg, ovf, exp_an(), exp_seg(), m_ovf);
         end
         @(negedge clk);
      end
      model_load(v);
      checks++;
      if (busy !== 1'b0 || an !== exp_an() || seg !== exp_seg() || ovf !== m_ovf) begin
         errors++;
         $display("FAIL %s done: busy=%b an=%b seg=%b ovf=%b, expected busy=0 an=%b seg=%b ovf=%b",
                  name, busy, an, seg, ovf, exp_an(), exp_seg(), m_ovf);
      end
   endtask

   task automatic test_scan(input int n, input string name);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         checks++;
         if (an !== exp_an() || seg !== exp_seg() || ovf !== m_ovf || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s scan k=%0d: an=%b seg=%b ovf=%b busy=%b, expected an=%b seg=%b ovf=%b busy=0",
                     name, k, an, seg, ovf, busy, exp_an(), exp_seg(), m_ovf);
         end
      end
   endtask

   task automatic test_reset();
      clr_n = 1'b0;
      model_reset();
      #12;
      checks++;
      if (an !== 4'b1110 || seg !== 7'b1000000 || busy !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset: an=%b seg=%b busy=%b ovf=%b, expected 1110 1000000 0 0", an, seg, busy, ovf);
      end
      @(negedge clk);
      clr_n = 1'b1;
      test_scan(20, "reset_scan");
   endtask

   task automatic test_1234();
      bit found;
      test_convert(1234, "v1234");
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (an === 4'b0111) found = 1'b1;
      end
      checks++;
      if (!found || seg !== 7'b1111001) begin
         errors++;
         $display("FAIL v1234_thousands: found=%b seg=%b, expected found=1 seg=1111001", found, seg);
      end
      test_scan(16, "v1234");
   endtask

   task automatic test_ovf();
      test_convert(9999, "v9999");
      test_scan(16, "v9999");
      test_convert(10000, "v10000");
      test_scan(16, "v10000");
      checks++;
      if (ovf !== 1'b1 || seg !== 7'b0111111) begin
         errors++;
         $display("FAIL ovf_dash: ovf=%b seg=%b, expected 1 0111111", ovf, seg);
      end
   endtask

   // Second update lands while busy and must be dropped.
   task automatic test_busy_drop();
      @(negedge clk);
      value = 14'd7;
      update = 1'b1;
      @(posedge clk);
      @(negedge clk);
      update = 1'b0;
      for (int k = 0; k < 15; k++) begin
         if (k == 3) begin value = 14'd42; update = 1'b1; end
         if (k == 4) update = 1'b0;
         checks++;
         if (busy !== 1'b1 || an !== exp_an() || seg !== exp_seg()) begin
            errors++;
            $display("FAIL busy_drop k=%0d: busy=%b an=%b seg=%b, expected busy=1 an=%b seg=%b",
                     k, busy, an, seg, exp_an(), exp_seg());
         end
         @(negedge clk);
      end
      model_load(7);
      checks++;
      if (busy !== 1'b0 || an !== exp_an() || seg !== exp_seg()) begin
         errors++;
         $display("FAIL busy_drop done: busy=%b an=%b seg=%b, expected busy=0 an=%b seg=%b",
                  busy, an, seg, exp_an(), exp_seg());
      end
      test_scan(20, "busy_drop");
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      value = 14'd5555;
      update = 1'b1;
      @(posedge clk);
      @(negedge clk);
      update = 1'b0;
      repeat (7) @(negedge clk);
      #2 clr_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (an !== 4'b1110 || seg !== 7'b1000000 || busy !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL abort_reset: an=%b seg=%b busy=%b ovf=%b, expected 1110 1000000 0 0", an, seg, busy, ovf);
      end
      @(negedge clk);
      clr_n = 1'b1;
      test_scan(40, "abort_after");
   endtask

   task automatic test_random();
      int v;
      for (int i = 0; i < 8; i++) begin
         v = (i % 4 == 3) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
         test_convert(v, "random");
         test_scan(int'($urandom_range(0, 16)), "random");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_1234();
      test_ovf();
      test_busy_drop();
      test_convert(0, "v0");
      test_scan(16, "v0");
      test_reset_abort();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_value_display.md
# seg7_value_display

Read-side consumer of the 14-bit value registers: accepts a 14-bit binary value on a one-cycle update strobe and converts it to four BCD digits with a sequential double-dabble engine. It then time-multiplexes those digits onto a 4-digit common-anode seven-segment display. It sits between the value register outputs and the board display pins.

## Interface
- REFRESH_DIV, 100000, clk cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range 2..2^20
- clk  input  1  rising-edge clock
- clr_n  input  1  asynchronous active-low reset
- value  input  14  binary value to display; sampled only on an accepted update
- update  input  1  one-cycle load strobe; accepted only when busy=0
- busy  output  1  conversion in progress; update is ignored while high
- ovf  output  1  last accepted value was >9999
- an  output  4  digit anodes, active-low, one-hot; an[0] is the ones digit
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low

## Operation
- Conversion FSM states: IDLE, SHIFT, DONE.
  - IDLE: on update=1, capture value into a 14-bit shift register, clear the 16-bit BCD accumulator and set busy, then go to SHIFT.
  - Capture also latches ovf_next = (value > 9999).
  - SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift {bcd, bin} left by 1.
  - A 4-bit count runs 0..13; after the 14th shift, go to DONE.
  - DONE: copy the accumulator into the displayed digit register d[3:0][3:0], copy ovf_next to ovf, clear busy and return to IDLE.
- When ovf_next=1, DONE loads all four digits with the dash code (segment g only). The conversion still runs its full length.
- Scan logic: a refresh counter counts 0..REFRESH_DIV-1. On wrap, the 2-bit digit index increments 0->1->2->3->0.
  - an = ~(4'b0001 << index).
  - seg = decode(d[index]).
- Decode for codes 0-9 is standard; the dash code gives 7'b0111111; any other code gives blank (7'b1111111).
- The displayed digits change only at DONE. During conversion the previous value stays on the display.
- Reset values:
  - state=IDLE, busy=0, ovf=0
  - d = 0000, refresh counter=0, index=0
  - an=4'b1110, seg=7'b1000000 ("0")
- Reset asserted mid-conversion aborts the conversion. Digits return to 0000 and the pending update is lost.

## Timing
- An update accepted at rising edge N produces:
  - busy=1 from N through N+14;
  - SHIFT occupying the cycles after edges N+1..N+14;
  - DONE at edge N+15, where the digits and ovf are updated and busy falls.
- Fixed latency of 15 cycles from strobe edge to new digits, independent of value.
- The next update is accepted at edge N+15 at the earliest (busy sampled low).
- An update arriving while busy=1 is dropped silently, with no queueing.
- an/seg are registered and change only on refresh wrap or at DONE, at most once per cycle.
- Conversion is independent of the scan phase; the scan counter is never reset by update.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN defined: leading zero digits above the most significant nonzero digit are blanked (seg=7'b1111111), as follows.
  - The ones digit is never blanked, so 0 shows "   0".
  - Blanking is computed at DONE and stored as a per-digit blank flag.
  - Dashes (ovf) are never blanked.
- Undefined: all four digits are always shown, e.g. 42 shows "0042".

## Structure
- Shared package seg7_pkg holds:
  - DIGIT_DASH (4'hA) and DIGIT_BLANK (4'hF) codes;
  - the conversion state enum typedef;
  - the 16-entry segment pattern constant array used by decode.
- One sub-module: bin14_to_bcd. It contains the SHIFT/DONE engine with start, busy, done and bcd[15:0]. The top level holds the digit register, ovf, blanking and the scan/decode logic.

## Test plan
- Reset, then release: an=1110, seg=1000000, busy=0, ovf=0; with REFRESH_DIV=4, an cycles 1110->1101->1011->0111->1110 every 4 clocks.
- update with value=1234: busy high for exactly 15 cycles; digits become 1,2,3,4; scanning index 3 shows seg=1111001 ("1").
- update with value=9999, then value=10000: the first shows 9999 with ovf=0; the second shows four dashes (seg=0111111) with ovf=1.
- update with value=42 while busy from a prior update with value=7: the second update is ignored and 0007 is displayed. With SEG7_LEADING_ZERO_BLANK_EN, digits 3..1 are blank and digit 0 is "7".
- Pulse clr_n low at cycle 8 of a conversion of value=5555: outputs return to reset values immediately (asynchronously), and no 5555 ever appears.
- value=0 with the macro defined: three blank digits and "0"; without the macro: "0000".
